// File: rtl/cfg_seq.sv
// cfg_seq: serialises one configuration bundle (data, wicp, tmpc, post) as
// tagged loader words onto the din ports of inst_test_b or inst_test_c.
// Optional build macro: CFG_SEQ_BROADCAST_EN drives every word onto both
// destinations and ignores cfg_target.
module cfg_seq #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_busy,
  input  logic                  cfg_target,
  input  logic [CWIDTH-1:0]     cfg_data_data,
  input  logic [CWIDTH-1:0]     cfg_wicp_data,
  input  logic [CWIDTH-1:0]     cfg_tmpc_data,
  input  logic [CWIDTH-1:0]     cfg_post_data,
  output logic                  din_b_valid,
  output logic [2*DWIDTH+2:0]   din_b_data,
  output logic                  din_c_valid,
  output logic [2*DWIDTH+2:0]   din_c_data,
  output logic                  cfg_done
);

  localparam int unsigned FW = 2 * DWIDTH;
  localparam int unsigned WW = FW + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [3:0]        cnt;
  logic [CWIDTH-1:0] fld [4];

  logic [1:0]        nxt_idx;
  logic [WW-1:0]     nxt_word;
  logic [WW-1:0]     first_word;
  logic              acc_b;
  logic              acc_c;
  logic              run_b;
  logic              run_c;

  // Word builders: first word comes straight from the inputs at accept,
  // later words from the latched fields; tag is field index + 1.
  always_comb begin
    nxt_idx    = idx + 2'd1;
    nxt_word   = {3'(nxt_idx) + 3'd1, FW'(fld[nxt_idx])};
    first_word = {3'b001, FW'(cfg_data_data)};
  end

`ifdef CFG_SEQ_BROADCAST_EN
  // Both destinations receive every word.
  always_comb begin
    acc_b = 1'b1;
    acc_c = 1'b1;
    run_b = 1'b1;
    run_c = 1'b1;
  end
`else
  logic tgt;

  // Route by the live target at accept, by the latched target afterwards.
  always_comb begin
    acc_b = ~cfg_target;
    acc_c = cfg_target;
    run_b = ~tgt;
    run_c = tgt;
  end

  // Latch the destination at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt <= 1'b0;
    end else if (state == S_IDLE && cfg_valid) begin
      tgt <= cfg_target;
    end
  end
`endif

  // Sequencer FSM with registered outputs; word strobes are one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      cnt         <= 4'd0;
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      din_b_valid <= 1'b0;
      din_b_data  <= '0;
      din_c_valid <= 1'b0;
      din_c_data  <= '0;
      for (int i = 0; i < 4; i++) fld[i] <= '0;
    end else begin
      din_b_valid <= 1'b0;
      din_b_data  <= '0;
      din_c_valid <= 1'b0;
      din_c_data  <= '0;
      cfg_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            state       <= S_SEND;
            idx         <= 2'd0;
            cfg_busy    <= 1'b1;
            fld[0]      <= cfg_data_data;
            fld[1]      <= cfg_wicp_data;
            fld[2]      <= cfg_tmpc_data;
            fld[3]      <= cfg_post_data;
            din_b_valid <= acc_b;
            din_b_data  <= acc_b ? first_word : '0;
            din_c_valid <= acc_c;
            din_c_data  <= acc_c ? first_word : '0;
          end
        end
        S_SEND: begin
          if (idx == 2'd3) begin
            state    <= S_DONE;
            cfg_done <= 1'b1;
          end else if (GAP == 0) begin
            idx         <= nxt_idx;
            din_b_valid <= run_b;
            din_b_data  <= run_b ? nxt_word : '0;
            din_c_valid <= run_c;
            din_c_data  <= run_c ? nxt_word : '0;
          end else begin
            state <= S_GAP;
            cnt   <= 4'(GAP - 1);
          end
        end
        S_GAP: begin
          if (cnt == 4'd0) begin
            state       <= S_SEND;
            idx         <= nxt_idx;
            din_b_valid <= run_b;
            din_b_data  <= run_b ? nxt_word : '0;
            din_c_valid <= run_c;
            din_c_data  <= run_c ? nxt_word : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_seq.sv
// tb_cfg_seq: scoreboard bench for cfg_seq. Two instances share inputs:
// ua uses GAP=2, uz uses GAP=0. Expected per-cycle output vectors are
// queued at offer time from the documented timing and popped every cycle.
module tb_cfg_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned FW = 2 * DW;
  localparam int unsigned WW = FW + 3;
  localparam int unsigned EW = 2 * WW + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_target;
  logic [CW-1:0] f0, f1, f2, f3;

  logic          a_busy, a_done, a_bv, a_cv;
  logic [WW-1:0] a_bd, a_cd;
  logic          z_busy, z_done, z_bv, z_cv;
  logic [WW-1:0] z_bd, z_cd;

  logic [EW-1:0] obs_a, obs_z;
  logic [EW-1:0] qa[$];
  logic [EW-1:0] qz[$];
  logic [EW-1:0] e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign obs_a = {a_busy, a_done, a_bv, a_bd, a_cv, a_cd};
  assign obs_z = {z_busy, z_done, z_bv, z_bd, z_cv, z_cd};

  cfg_seq #(.DWIDTH(DW), .CWIDTH(CW), .GAP(2)) ua (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_busy(a_busy),
    .cfg_target(cfg_target), .cfg_data_data(f0), .cfg_wicp_data(f1),
    .cfg_tmpc_data(f2), .cfg_post_data(f3),
    .din_b_valid(a_bv), .din_b_data(a_bd), .din_c_valid(a_cv), .din_c_data(a_cd),
    .cfg_done(a_done)
  );

  cfg_seq #(.DWIDTH(DW), .CWIDTH(CW), .GAP(0)) uz (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_busy(z_busy),
    .cfg_target(cfg_target), .cfg_data_data(f0), .cfg_wicp_data(f1),
    .cfg_tmpc_data(f2), .cfg_post_data(f3),
    .din_b_valid(z_bv), .din_b_data(z_bd), .din_c_valid(z_cv), .din_c_data(z_cd),
    .cfg_done(z_done)
  );

  // Expected output vector for one cycle.
  function automatic logic [EW-1:0] exp_vec(input bit busy, input bit done,
                                            input bit v, input bit tgt,
                                            input logic [WW-1:0] w);
    bit bv, cv;
`ifdef CFG_SEQ_BROADCAST_EN
    bv = v;
    cv = v;
`else
    bv = v && !tgt;
    cv = v && tgt;
`endif
    return {busy, done, bv, (bv ? w : WW'(0)), cv, (cv ? w : WW'(0))};
  endfunction

  // Queue the per-cycle expectations of one full sequence (cycles T+1 ..).
  task automatic push_seq(input int gap, input bit tgt,
                          input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                          input logic [CW-1:0] d2, input logic [CW-1:0] d3,
                          input bit to_z);
    logic [CW-1:0] fv[4];
    logic [EW-1:0] x;
    logic [WW-1:0] w;
    int len;
    int k;
    fv[0] = d0; fv[1] = d1; fv[2] = d2; fv[3] = d3;
    len = 5 + 3 * gap;
    for (int off = 1; off <= len; off++) begin
      if (off == len) begin
        x = exp_vec(1'b1, 1'b1, 1'b0, tgt, '0);
      end else if ((off - 1) % (gap + 1) == 0) begin
        k = (off - 1) / (gap + 1);
        w = {3'(k + 1), FW'(fv[k])};
        x = exp_vec(1'b1, 1'b0, 1'b1, tgt, w);
      end else begin
        x = exp_vec(1'b1, 1'b0, 1'b0, tgt, '0);
      end
      if (to_z) qz.push_back(x);
      else      qa.push_back(x);
    end
  endtask

  task automatic offer(input bit tgt, input logic [CW-1:0] d0, input logic [CW-1:0] d1,
                       input logic [CW-1:0] d2, input logic [CW-1:0] d3);
    @(negedge clk);
    cfg_target = tgt;
    f0 = d0; f1 = d1; f2 = d2; f3 = d3;
    cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_target = 1'b0;
    f0 = '0; f1 = '0; f2 = '0; f3 = '0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_a !== '0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=0", obs_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (obs_a !== '0) begin
        bad++;
        $display("FAIL idle_a cyc=%0d got=%h want=0", i, obs_a);
      end
      total++;
      if (obs_z !== '0) begin
        bad++;
        $display("FAIL idle_z cyc=%0d got=%h want=0", i, obs_z);
      end
    end
  endtask

  task automatic test_basic();
    offer(1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push_seq(2, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid = 1'b0;
      if (qa.size() > 0) e = qa.pop_front();
      else e = '0;
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL basic cyc=T+%0d got=%h want=%h", i + 1, obs_a, e);
      end
    end
  endtask

  task automatic test_latch_drop();
    offer(1'b1, 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    push_seq(2, 1'b1, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 1'b0);
    qa.push_back('0);
    push_seq(2, 1'b1, 16'h5EED, 16'hBEEF, 16'hCAFE, 16'hD00D, 1'b0);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (qa.size() > 0) e = qa.pop_front();
      else e = '0;
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL latch_drop cyc=T+%0d got=%h want=%h", i + 1, obs_a, e);
      end
      if (i == 0) begin
        f0 = 16'h5EED; f1 = 16'hBEEF; f2 = 16'hCAFE; f3 = 16'hD00D;
        cfg_target = 1'b0;
      end
      if (i == 9) cfg_target = 1'b1;
      if (i == 12) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_gap0();
    offer(1'b1, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    push_seq(0, 1'b1, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid = 1'b0;
      if (qz.size() > 0) e = qz.pop_front();
      else e = '0;
      total++;
      if (obs_z !== e) begin
        bad++;
        $display("FAIL gap0 cyc=T+%0d got=%h want=%h", i + 1, obs_z, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    offer(1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    push_seq(2, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0);
    while (qa.size() > 5) void'(qa.pop_back());
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid = 1'b0;
      if (qa.size() > 0) e = qa.pop_front();
      else e = '0;
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL mid_reset cyc=T+%0d got=%h want=%h", i + 1, obs_a, e);
      end
      if (i == 4) rst = 1'b1;
      if (i == 5) rst = 1'b0;
    end
    offer(1'b1, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD);
    push_seq(2, 1'b1, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) cfg_valid = 1'b0;
      if (qa.size() > 0) e = qa.pop_front();
      else e = '0;
      total++;
      if (obs_a !== e) begin
        bad++;
        $display("FAIL restart cyc=T+%0d got=%h want=%h", i + 1, obs_a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (4) @(negedge clk);
    test_latch_drop();
    repeat (16) @(negedge clk);
    test_gap0();
    repeat (16) @(negedge clk);
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_seq.md
# cfg_seq

Configuration sequencer for the `test_din` loader ports in the `test` top level. It accepts one configuration bundle (data, wicp, tmpc and post fields) through a valid/busy handshake, then serialises the four fields as tagged words onto the `din_valid`/`din_data` inputs of either the `inst_test_b` instance or the `inst_test_c` instance. Fixed inter-word gaps pace the words. The block replaces direct tie-off of the `test_din` loader ports and gives them a single owner.

## Interface
Parameters:
- `DWIDTH`, 16: datapath width of the `test_din` instances; the loader word is `2*DWIDTH+3` bits.
- `CWIDTH`, 16: width of each configuration field. Must satisfy `CWIDTH <= 2*DWIDTH`.
- `GAP`, 2: idle cycles inserted between consecutive words. Range 0..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  bundle offer.
- `cfg_busy`  out  1  sequencer occupied; an offer is ignored while this is high.
- `cfg_target`  in  1  destination select: 0 = `inst_test_b`, 1 = `inst_test_c`. Sampled at accept.
- `cfg_data_data`  in  CWIDTH  field 0.
- `cfg_wicp_data`  in  CWIDTH  field 1.
- `cfg_tmpc_data`  in  CWIDTH  field 2.
- `cfg_post_data`  in  CWIDTH  field 3.
- `din_b_valid`  out  1  word strobe to `inst_test_b`.
- `din_b_data`  out  2*DWIDTH+3  word to `inst_test_b`.
- `din_c_valid`  out  1  word strobe to `inst_test_c`.
- `din_c_data`  out  2*DWIDTH+3  word to `inst_test_c`.
- `cfg_done`  out  1  one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, SEND, GAP, DONE. Registers: 2-bit word index, 4-bit gap counter, latched fields, latched target.
- IDLE → SEND: on `cfg_valid=1` with `cfg_busy=0`. On the same edge, all four fields and `cfg_target` are latched; later input changes have no effect.
- SEND: exactly one word is driven for one cycle.
  - If index = 3 → DONE.
  - Else if `GAP = 0` → stay in SEND with index+1.
  - Else → GAP with the gap counter loaded to `GAP-1`.
- GAP: all valids are 0. When the counter reaches 0 → SEND with index+1; otherwise decrement.
- DONE: `cfg_done=1` for one cycle, then → IDLE.
- Word format: `{tag[2:0], zero-extended field[2*DWIDTH-1:0]}`.
  - Tags: data = 3'b001, wicp = 3'b010, tmpc = 3'b011, post = 3'b100.
  - Order is always data, wicp, tmpc, post.
- Destination routing:
  - The non-selected output has `valid=0` and `data=0`.
  - Data outputs are 0 whenever their `valid` is 0.
- `cfg_busy` is 1 in SEND, GAP and DONE; 0 in IDLE. Offers made while busy are dropped, not queued.
- Reset (any state, including mid-sequence) values:
  - State = IDLE, index = 0, counter = 0.
  - All outputs 0: `cfg_busy`, `cfg_done`, both valids, both data buses.
  - A partial sequence is abandoned with no `cfg_done`.
  - `rst` has priority over `cfg_valid` on the same edge.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Accept edge = cycle T. Word k is valid in cycle T+1+k*(GAP+1) for k = 0..3.
- `cfg_done` is high in cycle T+5+3*GAP.
- `cfg_busy` is high from T+1 through T+5+3*GAP inclusive.
- The earliest next accept is the edge at the end of cycle T+6+3*GAP.
- GAP=2: words at T+1, T+4, T+7, T+10; done at T+11. GAP=0: words at T+1..T+4; done at T+5.

## Configuration
- `CFG_SEQ_BROADCAST_EN` defined:
  - `cfg_target` is ignored.
  - Every word drives both outputs identically in the same cycle: both valids high, both data buses equal.
- Not defined: routing follows the latched `cfg_target` as described above.
- Timing is identical in both builds.

## Test plan
- Reset then idle, GAP=2: every output reads 0 for 10 cycles.
- Basic sequence to b: `cfg_target=0`, fields 0x1111/0x2222/0x3333/0x4444 → in order:
  - `din_b_data` = {001,0x1111}, {010,0x2222}, {011,0x3333}, {100,0x4444} at T+1, T+4, T+7, T+10.
  - `din_c_valid` stays 0.
  - `cfg_done` pulses at T+11.
  - `cfg_busy` is high T+1..T+11.
- Latch and drop check: `cfg_target=1`, fields are changed and `cfg_valid` is held high during the sequence → `din_c` carries the original values only. Exactly one sequence completes before the next accept at the end of T+12.
- GAP=0 back-to-back: four consecutive valid cycles T+1..T+4; done at T+5.
- Reset mid-sequence: assert `rst` in the cycle after word 1 → all outputs 0 next cycle, no `cfg_done`. A fresh offer after reset restarts from the data word.
- `CFG_SEQ_BROADCAST_EN` build, `cfg_target=0` → `din_b` and `din_c` are identical on every cycle of the sequence.
